ifu_fetch: RTL and testbench

IFU_FETCH -- requirements
Module: ifu_fetch

---
 rtl/ifu_fetch.sv | 113 +++++++++++
 tb/tb_ifu_fetch.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch unit: PC, IR and IDLE/FETCH/VALID handshake FSM
// Optional consumed-instruction counter built only when IFU_INSTR_CNT_EN is defined.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  OpCode,
  output logic [5:0]  funct,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        jump,
  input  logic        Branch,
  input  logic        Zero,
  output logic [31:0] instr_cnt
);

  typedef enum logic [1:0] {IDLE, FETCH, VALID} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] pc_seq;
  logic [31:0] br_off;
  logic [31:0] pc_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      pc_out_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      pc_out_q <= pc_out_d;
    end
  end

  // Target is computed from the instruction held in IR, not from the live PC.
  assign pc_seq = pc_out_q + 32'd4;
  assign br_off = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

  always_comb begin
    pc_next = pc_seq;
    if (jump) begin
      pc_next = {pc_seq[31:28], ir_q[25:0], 2'b00};
    end else if (Branch && Zero) begin
      pc_next = pc_seq + br_off;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    pc_out_d = pc_out_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          ir_d     = imem_rdata;
          pc_out_d = pc_q;
          state_d  = VALID;
        end
      end
      VALID: begin
        if (instr_ready) begin
          pc_d    = pc_next;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == VALID);
  assign instr       = ir_q;
  assign OpCode      = ir_q[31:26];
  assign funct       = ir_q[5:0];
  assign pc_out      = pc_out_q;

`ifdef IFU_INSTR_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (instr_valid && instr_ready) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign instr_cnt = cnt_q;
`else
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - self-checking bench for ifu_fetch: vector table plus scoreboard queue
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  OpCode;
  logic [5:0]  funct;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        jump;
  logic        Branch;
  logic        Zero;
  logic [31:0] instr_cnt;

  ifu_fetch #(.RESET_PC(32'h0000_3000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .OpCode      (OpCode),
    .funct       (funct),
    .pc_out      (pc_out),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jump        (jump),
    .Branch      (Branch),
    .Zero        (Zero),
    .instr_cnt   (instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic        j;
    logic        b;
    logic        z;
    logic [31:0] pc;
    logic [31:0] next;
  } vec_t;

  typedef struct {
    logic [31:0] word;
    logic [31:0] pc;
  } exp_t;

  vec_t vecs[13];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   hs    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic [31:0] w, input logic j, input logic b,
                              input logic z, input logic [31:0] pc, input logic [31:0] nx);
    vec_t v;
    v.word = w; v.j = j; v.b = b; v.z = z; v.pc = pc; v.next = nx;
    return v;
  endfunction

  task automatic push_exp(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    e.word = w;
    e.pc   = pc;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_instr"}, instr, e.word);
      chk({tag, "_pc_out"}, pc_out, e.pc);
      chk({tag, "_opcode"}, {26'd0, OpCode}, {26'd0, e.word[31:26]});
      chk({tag, "_funct"}, {26'd0, funct}, {26'd0, e.word[5:0]});
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef IFU_INSTR_CNT_EN
    return n;
`else
    return 32'd0 & n;
`endif
  endfunction

  initial begin
    int w;
    logic [31:0] held;

    // Chained program: each entry's next equals the following entry's pc.
    vecs[0]  = mk(32'h0000_0021, 0, 0, 0, 32'h0000_3000, 32'h0000_3004);
    vecs[1]  = mk(32'h0000_0021, 0, 0, 0, 32'h0000_3004, 32'h0000_3008);
    vecs[2]  = mk(32'h0800_0C04, 1, 0, 0, 32'h0000_3008, 32'h0000_3010);
    vecs[3]  = mk(32'h1000_FFFF, 0, 1, 1, 32'h0000_3010, 32'h0000_3010);
    vecs[4]  = mk(32'h1000_FFFF, 0, 1, 0, 32'h0000_3010, 32'h0000_3014);
    vecs[5]  = mk(32'h0800_0C10, 1, 0, 0, 32'h0000_3014, 32'h0000_3040);
    vecs[6]  = mk(32'h1000_0004, 1, 1, 1, 32'h0000_3040, 32'h0000_0010);
    vecs[7]  = mk(32'h1000_0003, 0, 1, 1, 32'h0000_0010, 32'h0000_0020);
    vecs[8]  = mk(32'h1000_0003, 0, 1, 0, 32'h0000_0020, 32'h0000_0024);
    vecs[9]  = mk(32'h0000_0021, 0, 0, 1, 32'h0000_0024, 32'h0000_0028);
    vecs[10] = mk(32'h1000_FFF4, 0, 1, 1, 32'h0000_0028, 32'hFFFF_FFFC);
    vecs[11] = mk(32'h0000_0021, 0, 0, 0, 32'hFFFF_FFFC, 32'h0000_0000);
    vecs[12] = mk(32'h0800_0C00, 1, 0, 0, 32'h0000_0000, 32'h0000_3000);

    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
    instr_ready = 1'b0; jump = 1'b0; Branch = 1'b0; Zero = 1'b0;
    step();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc_out", pc_out, 32'h0000_3000);
    chk("rst_cnt", instr_cnt, 32'h0);
    rst = 1'b0;
    step();

    // Ack withheld for five FETCH cycles, then a jump at 0x3000
    chk("stall_req0", {31'd0, imem_req}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_req", {31'd0, imem_req}, 32'd1);
      chk("stall_addr", imem_addr, 32'h0000_3000);
      chk("stall_valid", {31'd0, instr_valid}, 32'd0);
      step();
    end
    imem_rdata = 32'h0800_0C10; imem_ack = 1'b1;
    push_exp(32'h0800_0C10, 32'h0000_3000);
    step();
    imem_ack = 1'b0; imem_rdata = $urandom;
    chk("stall_valid_after", {31'd0, instr_valid}, 32'd1);
    pop_cmp("jmp");
    jump = 1'b1; instr_ready = 1'b1;
    step();
    hs++;
    jump = 1'b0; instr_ready = 1'b0;
    chk("jmp_addr", imem_addr, 32'h0000_3040);
    chk("jmp_req", {31'd0, imem_req}, 32'd1);

    // VALID stall with stray ack, then asynchronous reset mid-stall
    imem_rdata = 32'h1234_5678; imem_ack = 1'b1;
    push_exp(32'h1234_5678, 32'h0000_3040);
    step();
    imem_rdata = 32'hDEAD_BEEF;
    pop_cmp("hold0");
    held = instr;
    for (int i = 0; i < 3; i++) begin
      jump = 1'b1; Branch = 1'b1; Zero = 1'b1;
      step();
      chk("hold_valid", {31'd0, instr_valid}, 32'd1);
      chk("hold_instr", instr, 32'h1234_5678);
      chk("hold_pc_out", pc_out, 32'h0000_3040);
      chk("hold_req", {31'd0, imem_req}, 32'd0);
    end
    jump = 1'b0; Branch = 1'b0; Zero = 1'b0;
    chk("hold_cnt", instr_cnt, exp_cnt(hs));
    #2 rst = 1'b1;
    #1;
    chk("arst_instr", instr, 32'h0);
    chk("arst_valid", {31'd0, instr_valid}, 32'd0);
    chk("arst_pc_out", pc_out, 32'h0000_3000);
    chk("arst_cnt", instr_cnt, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    hs = 0;
    step();
    chk("late_ack_valid", {31'd0, instr_valid}, 32'd0);
    chk("late_ack_instr", instr, 32'h0);
    imem_ack = 1'b0;

    // Table program: ack in the same cycle as the request, ready immediately
    for (int i = 0; i < 13; i++) begin
      w = 0;
      while (!imem_req && w < 20) begin
        step();
        w++;
      end
      chk($sformatf("v%0d_req", i), {31'd0, imem_req}, 32'd1);
      chk($sformatf("v%0d_tput", i), w, 0);
      chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].pc);
      imem_rdata = vecs[i].word; imem_ack = 1'b1;
      push_exp(vecs[i].word, vecs[i].pc);
      step();
      imem_ack = 1'b0; imem_rdata = $urandom;
      chk($sformatf("v%0d_valid", i), {31'd0, instr_valid}, 32'd1);
      pop_cmp($sformatf("v%0d", i));
      jump = vecs[i].j; Branch = vecs[i].b; Zero = vecs[i].z; instr_ready = 1'b1;
      step();
      hs++;
      instr_ready = 1'b0;
      jump = $urandom_range(0, 1); Branch = $urandom_range(0, 1); Zero = $urandom_range(0, 1);
      chk($sformatf("v%0d_next", i), imem_addr, vecs[i].next);
    end
    jump = 1'b0; Branch = 1'b0; Zero = 1'b0;
    chk("final_cnt", instr_cnt, exp_cnt(hs));
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
